vctrl_sequencer: RTL

Multi-cycle control sequencer for the scalar+vector datapath: decodes the instruction word the datapath returns each cycle and drives every datapath control input. Scalar and vector-ALU instructions complete in one cycle. Vector unit-stride loads and stores are split into four 32-bit element beats through the scalar data memory, with the PC held until the last beat. It sits directly upstream of the combined datapath and closes the fetch/decode loop.

---
 rtl/vctrl_sequencer_if.sv | 40 ++++
 rtl/vctrl_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vctrl_sequencer_if.sv
// rtl/vctrl_sequencer_if.sv - control bus between vctrl_sequencer and the scalar+vector datapath
interface vctrl_sequencer_if;
  logic [31:0] inst;
  logic        pc_hold;
  logic [1:0]  elem_idx;
  logic        VX;
  logic        xRegWrite;
  logic [2:0]  xImmType;
  logic [1:0]  xALUOp;
  logic        xOpd1Sel;
  logic        xOpd2Sel;
  logic [1:0]  xWBSel;
  logic [1:0]  branch;
  logic [2:0]  VWe0, VWe1, VWe2, VWe3;
  logic [2:0]  REn0, REn1, REn2, REn3;
  logic        VWBSel;
  logic [3:0]  VWEn;
  logic [2:0]  Opd2Sel;
  logic [1:0]  Opd1Sel;
  logic        illegal;
  logic [31:0] cyc_cnt;
  logic [31:0] vinst_cnt;
  logic [31:0] hold_cnt;

  // Sequencer side: consumes the instruction, drives every control
  modport master (
    input  inst,
    output pc_hold, elem_idx, VX, xRegWrite, xImmType, xALUOp, xOpd1Sel, xOpd2Sel,
           xWBSel, branch, VWe0, VWe1, VWe2, VWe3, REn0, REn1, REn2, REn3,
           VWBSel, VWEn, Opd2Sel, Opd1Sel, illegal, cyc_cnt, vinst_cnt, hold_cnt
  );

  // Datapath side: returns the instruction, obeys the controls
  modport slave (
    output inst,
    input  pc_hold, elem_idx, VX, xRegWrite, xImmType, xALUOp, xOpd1Sel, xOpd2Sel,
           xWBSel, branch, VWe0, VWe1, VWe2, VWe3, REn0, REn1, REn2, REn3,
           VWBSel, VWEn, Opd2Sel, Opd1Sel, illegal, cyc_cnt, vinst_cnt, hold_cnt
  );
endinterface

// File: rtl/vctrl_sequencer.sv
// rtl/vctrl_sequencer.sv - scalar+vector control sequencer, optional counters under VCTRL_PERF_EN
module vctrl_sequencer (
  input  logic               clk,
  input  logic               rst,
  vctrl_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_VMEM = 2'd2
  } state_t;

  localparam logic [2:0] WORD = 3'b010;

  state_t     state_q, state_d;
  logic [1:0] elem_idx_q, elem_idx_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_vmem;
  logic       is_store;
  logic       vmem_beat;
  logic       unused_inst;

  assign opcode      = bus.inst[6:0];
  assign funct3      = bus.inst[14:12];
  assign is_vmem     = ((opcode == 7'h07) || (opcode == 7'h27)) && (funct3 == 3'b110);
  // Opcode bit 5 separates STORE-FP (0x27) from LOAD-FP (0x07); inst is held stable across beats
  assign is_store    = bus.inst[5];
  assign unused_inst = ^{bus.inst[31:15], bus.inst[11:7]};

  // State and element-beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      elem_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
    end
  end

  // Next state and decode of every datapath control
  always_comb begin
    state_d       = state_q;
    elem_idx_d    = elem_idx_q;
    vmem_beat     = 1'b0;
    bus.pc_hold   = 1'b0;
    bus.elem_idx  = 2'd0;
    bus.VX        = 1'b0;
    bus.xRegWrite = 1'b0;
    bus.xImmType  = 3'd0;
    bus.xALUOp    = 2'd0;
    bus.xOpd1Sel  = 1'b0;
    bus.xOpd2Sel  = 1'b0;
    bus.xWBSel    = 2'd0;
    bus.branch    = 2'd0;
    bus.VWe0      = 3'd0;
    bus.VWe1      = 3'd0;
    bus.VWe2      = 3'd0;
    bus.VWe3      = 3'd0;
    bus.REn0      = 3'd0;
    bus.REn1      = 3'd0;
    bus.REn2      = 3'd0;
    bus.REn3      = 3'd0;
    bus.VWBSel    = 1'b0;
    bus.VWEn      = 4'd0;
    bus.Opd2Sel   = 3'd0;
    bus.Opd1Sel   = 2'd0;
    bus.illegal   = 1'b0;

    if (rst) begin
      // Reset overrides the current state so a half-finished vector access stops at once
      state_d     = S_IDLE;
      elem_idx_d  = 2'd0;
      bus.pc_hold = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bus.pc_hold = 1'b1;
          state_d     = S_RUN;
        end
        S_RUN: begin
          case (opcode)
            7'h33: begin
              bus.xRegWrite = 1'b1;
              bus.xALUOp    = 2'd2;
            end
            7'h13: begin
              bus.xRegWrite = 1'b1;
              bus.xALUOp    = 2'd2;
              bus.xOpd2Sel  = 1'b1;
              bus.xImmType  = 3'd0;
            end
            7'h03: begin
              bus.xRegWrite = 1'b1;
              bus.xALUOp    = 2'd0;
              bus.xOpd2Sel  = 1'b1;
              bus.xWBSel    = 2'd1;
            end
            7'h23: begin
              bus.xImmType  = 3'd1;
              bus.xOpd2Sel  = 1'b1;
            end
            7'h63: begin
              bus.branch    = 2'd1;
              bus.xImmType  = 3'd2;
              bus.xALUOp    = 2'd1;
            end
            7'h6F: begin
              bus.branch    = 2'd2;
              bus.xImmType  = 3'd4;
              bus.xWBSel    = 2'd2;
              bus.xRegWrite = 1'b1;
            end
            7'h37: begin
              bus.xImmType  = 3'd3;
              bus.xRegWrite = 1'b1;
            end
            7'h57: begin
              case (funct3)
                3'b000: begin
                  bus.VX = 1'b1; bus.VWEn = 4'hF; bus.Opd2Sel = 3'd0;
                end
                3'b100: begin
                  bus.VX = 1'b1; bus.VWEn = 4'hF; bus.Opd2Sel = 3'd1;
                end
                3'b011: begin
                  bus.VX = 1'b1; bus.VWEn = 4'hF; bus.Opd2Sel = 3'd2;
                end
                default: bus.illegal = 1'b1;
              endcase
            end
            7'h07, 7'h27: begin
              if (is_vmem) begin
                // Beat 0 goes out from RUN; VMEM carries beats 1..3
                vmem_beat  = 1'b1;
                state_d    = S_VMEM;
                elem_idx_d = 2'd1;
              end else begin
                bus.illegal = 1'b1;
              end
            end
            default: bus.illegal = 1'b1;
          endcase
        end
        S_VMEM: begin
          vmem_beat = 1'b1;
          if (elem_idx_q == 2'd3) begin
            state_d    = S_RUN;
            elem_idx_d = 2'd0;
          end else begin
            elem_idx_d = elem_idx_q + 2'd1;
          end
        end
        default: begin
          state_d    = S_IDLE;
          elem_idx_d = 2'd0;
        end
      endcase

      if (vmem_beat) begin
        // One lane per beat; address is rs1 + imm + 4*elem_idx
        bus.elem_idx = elem_idx_q;
        bus.VX       = 1'b1;
        bus.pc_hold  = (elem_idx_q != 2'd3);
        bus.xOpd1Sel = 1'b0;
        bus.xOpd2Sel = 1'b1;
        if (is_store) begin
          bus.Opd1Sel = 2'd1;
          case (elem_idx_q)
            2'd0:    bus.VWe0 = WORD;
            2'd1:    bus.VWe1 = WORD;
            2'd2:    bus.VWe2 = WORD;
            default: bus.VWe3 = WORD;
          endcase
        end else begin
          bus.VWBSel = 1'b1;
          bus.VWEn   = 4'b0001 << elem_idx_q;
          case (elem_idx_q)
            2'd0:    bus.REn0 = WORD;
            2'd1:    bus.REn1 = WORD;
            2'd2:    bus.REn2 = WORD;
            default: bus.REn3 = WORD;
          endcase
        end
      end
    end
  end

`ifdef VCTRL_PERF_EN
  logic [31:0] cyc_cnt_q, vinst_cnt_q, hold_cnt_q;
  logic        vinst_done;

  // A vector instruction completes on a legal OP-V in RUN or on the last memory beat
  assign vinst_done = ((state_q == S_RUN) && (opcode == 7'h57) && !bus.illegal) ||
                      ((state_q == S_VMEM) && (elem_idx_q == 2'd3));

  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q   <= 32'd0;
      vinst_cnt_q <= 32'd0;
      hold_cnt_q  <= 32'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (vinst_done)
        vinst_cnt_q <= vinst_cnt_q + 32'd1;
      if (bus.pc_hold && (state_q != S_IDLE))
        hold_cnt_q <= hold_cnt_q + 32'd1;
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.vinst_cnt = vinst_cnt_q;
  assign bus.hold_cnt  = hold_cnt_q;
`else
  assign bus.cyc_cnt   = 32'd0;
  assign bus.vinst_cnt = 32'd0;
  assign bus.hold_cnt  = 32'd0;
`endif

endmodule
